// File: rtl/brisc_pkg.sv
// brisc_pkg: shared core widths and the writeback request bundle.
package brisc_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: parameterised sync FIFO, circular buffer with wrapping pointers, async active-high reset.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter merging the ALU pipe (A) and long-latency results (B) onto the RF write port.
// WB_BYPASS_EN adds same-cycle forwarding hit flags for decode.
module wb_arbiter
  import brisc_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a_valid,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic b_valid,
  output logic b_ready,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic stall_req
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] fwd_rs1_addr,
  input  logic [REG_ADDR_W-1:0] fwd_rs2_addr,
  output logic fwd_rs1_hit,
  output logic fwd_rs2_hit
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  wb_req_t a_req, b_req, head, rf_q;
  logic [CW-1:0] count;
  logic [SW-1:0] starve, starve_nxt;
  logic full, empty, b_fire, push, pop, direct;
  assign a_req = '{rd: a_rd, data: a_data};
  assign b_req = '{rd: b_rd, data: b_data};
  assign b_ready = count < CW'(FIFO_DEPTH);
  assign b_fire = b_valid && b_ready;
  assign pop = !a_valid && !empty;
  // rd==0 results from B are acknowledged but never buffered or written
  assign push = b_fire && b_rd != '0 && !full && (a_valid || !empty);
  assign direct = b_fire && b_rd != '0 && !a_valid && empty;
  assign starve_nxt = (pop || empty) ? '0 :
                      (a_valid && starve != SW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;
  assign rf_rd = rf_q.rd;
  assign rf_wdata = rf_q.data;
  wb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(wb_req_t))) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(b_req), .dout(head),
    .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rf_we <= 1'b0;
      rf_q <= '0;
      starve <= '0;
      stall_req <= 1'b0;
    end else begin
      rf_we <= a_valid ? a_rd != '0 : !empty ? 1'b1 : direct;
      rf_q <= a_valid ? a_req : !empty ? head : direct ? b_req : rf_q;
      starve <= starve_nxt;
      stall_req <= starve_nxt == SW'(STARVE_LIMIT);
    end
`ifdef WB_BYPASS_EN
  assign fwd_rs1_hit = rf_we && rf_rd == fwd_rs1_addr && fwd_rs1_addr != '0;
  assign fwd_rs2_hit = rf_we && rf_rd == fwd_rs2_addr && fwd_rs2_addr != '0;
`endif
endmodule
